// File: rtl/lut_settle_eval.sv
// N-input truth-table evaluator: output is published only after the input vector
// has been stable for SETTLE cycles; the table can be reloaded serially at runtime.
module lut_settle_eval #(
    parameter int                      N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]    TT_RESET = 8'hDF,
    parameter int                      SETTLE   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] in,
    output logic            out,
    output logic            out_valid,
    input  logic            ld_start,
    input  logic            ld_en,
    input  logic            ld_bit,
    output logic            ld_busy,
    output logic            ld_done
);

    localparam int              TT_W        = 1 << N_IN;
    localparam logic [N_IN:0]   LAST_IDX    = (N_IN + 1)'(TT_W - 1);
    localparam logic [N_IN:0]   BIT_ONE     = (N_IN + 1)'(1);
    localparam logic [7:0]      SETTLE_CNT  = 8'(SETTLE);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic {
        RUN,
        LOAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TT_W-1:0]   tt;
    logic [TT_W-1:0]   shadow;
    logic [TT_W-1:0]   shadow_merged;
    logic [N_IN-1:0]   in_q;
    logic [7:0]        cnt;
    logic [N_IN:0]     bit_cnt;
    logic              accept;
    logic              commit;
    logic              restart;

    // The final bit is merged combinationally so the table commits on the edge
    // that accepts it, without waiting a cycle for shadow to catch up.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        commit        = 1'b0;
        restart       = 1'b0;
        shadow_merged = shadow;
        shadow_merged[bit_cnt[N_IN-1:0]] = ld_bit;
        case (state)
            RUN: begin
                if (ld_start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    restart = 1'b1;
                end else if (ld_en) begin
                    accept = 1'b1;
                    if (bit_cnt == LAST_IDX) begin
                        commit     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tt      <= TT_RESET;
            shadow  <= '0;
            bit_cnt <= '0;
            ld_done <= 1'b0;
        end else begin
            ld_done <= commit;
            if (restart) begin
                bit_cnt <= '0;
            end else if (accept) begin
                shadow[bit_cnt[N_IN-1:0]] <= ld_bit;
                bit_cnt                   <= bit_cnt + BIT_ONE;
            end
            if (commit) begin
                tt <= shadow_merged;
            end
        end
    end

    // An input change takes priority over a commit; both restart the settle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q      <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in != in_q) begin
                in_q      <= in;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else if (commit) begin
                cnt       <= '0;
                out_valid <= 1'b0;
            end else if (cnt < SETTLE_CNT) begin
                cnt <= cnt + 8'd1;
                if (cnt == SETTLE_LAST) begin
                    out       <= tt[in_q];
                    out_valid <= 1'b1;
                end
            end
        end
    end

    assign ld_busy = (state == LOAD);

endmodule

// File: tb/tb_lut_settle_eval.sv
// Bench for lut_settle_eval: two configurations, expected values queued by the
// stimulus and popped by per-instance monitors on each rising out_valid.
module tb_lut_settle_eval;

    logic       clk;
    logic       reset;

    logic [2:0] in0;
    logic       out0, valid0, busy0, done0;
    logic       ld_start0, ld_en0, ld_bit0;

    logic [3:0] in1;
    logic       out1, valid1, busy1, done1;
    logic       ld_start1, ld_en1, ld_bit1;

    int checks   = 0;
    int failures = 0;

    logic q0[$];
    logic q1[$];

    logic [7:0]  tt0_ref = 8'hDF;
    logic [15:0] tt1_ref = 16'h8000;

    lut_settle_eval #(.N_IN(3), .TT_RESET(8'hDF), .SETTLE(2)) dut0 (
        .clk(clk), .reset(reset), .in(in0), .out(out0), .out_valid(valid0),
        .ld_start(ld_start0), .ld_en(ld_en0), .ld_bit(ld_bit0),
        .ld_busy(busy0), .ld_done(done0)
    );

    lut_settle_eval #(.N_IN(4), .TT_RESET(16'h8000), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .in(in1), .out(out1), .out_valid(valid1),
        .ld_start(ld_start1), .ld_en(ld_en1), .ld_bit(ld_bit1),
        .ld_busy(busy1), .ld_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive a new input, expect out_valid low after the capture edge and high
    // SETTLE edges later; the value itself is checked by the monitor.
    task automatic applyStimulus(input int dut, input logic [3:0] value, input int hold, input logic exp);
        int settle;
        settle = (dut == 0) ? 2 : 1;
        if (dut == 0) begin
            in0 = value[2:0];
            q0.push_back(exp);
        end else begin
            in1 = value;
            q1.push_back(exp);
        end
        @(posedge clk); #1;
        checkOutput("valid_drop", (dut == 0) ? valid0 : valid1, 1'b0);
        repeat (settle) @(posedge clk);
        #1;
        checkOutput("valid_rise", (dut == 0) ? valid0 : valid1, 1'b1);
        repeat (hold - 1 - settle) @(posedge clk);
        #1;
    endtask

    task automatic loadTable(input logic [7:0] data, input bit gaps);
        ld_start0 = 1'b1;
        ld_en0    = 1'b0;
        @(posedge clk); #1;
        ld_start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i % 3 == 1)) begin
                ld_en0 = 1'b0;
                checkOutput("ld_busy_gap", busy0, 1'b1);
                @(posedge clk); #1;
            end
            ld_en0  = 1'b1;
            ld_bit0 = data[i];
            checkOutput("ld_busy", busy0, 1'b1);
            checkOutput("ld_done_low", done0, 1'b0);
            if (i == 7) q0.push_back(data[in0]);
            @(posedge clk); #1;
        end
        ld_en0 = 1'b0;
        checkOutput("ld_busy_fall", busy0, 1'b0);
        checkOutput("ld_done_pulse", done0, 1'b1);
        checkOutput("commit_valid_drop", valid0, 1'b0);
        @(posedge clk); #1;
        checkOutput("ld_done_single", done0, 1'b0);
        @(posedge clk); #1;
        checkOutput("commit_valid_rise", valid0, 1'b1);
    endtask

    always @(negedge clk) begin : monitor0
        static logic prev_v0 = 1'b0;
        logic e;
        if (reset) begin
            prev_v0 = 1'b0;
        end else begin
            if (valid0 && !prev_v0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb0_unexpected out=%0b with empty queue at %0t", out0, $time);
                end else begin
                    e = q0.pop_front();
                    checkOutput("sb0_out", out0, e);
                end
            end
            prev_v0 = valid0;
        end
    end

    always @(negedge clk) begin : monitor1
        static logic prev_v1 = 1'b0;
        logic e;
        if (reset) begin
            prev_v1 = 1'b0;
        end else begin
            if (valid1 && !prev_v1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb1_unexpected out=%0b with empty queue at %0t", out1, $time);
                end else begin
                    e = q1.pop_front();
                    checkOutput("sb1_out", out1, e);
                end
            end
            prev_v1 = valid1;
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic prev_out;
        reset     = 1'b1;
        in0       = 3'd5;
        in1       = 4'd0;
        ld_start0 = 1'b0; ld_en0 = 1'b0; ld_bit0 = 1'b0;
        ld_start1 = 1'b0; ld_en1 = 1'b0; ld_bit1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out0", out0, 1'b0);
        checkOutput("rst_valid0", valid0, 1'b0);
        checkOutput("rst_busy0", busy0, 1'b0);
        checkOutput("rst_done0", done0, 1'b0);
        checkOutput("rst_valid1", valid1, 1'b0);

        // in=5 present before the first edge after reset: valid after two more edges
        q0.push_back(1'b0);
        q1.push_back(1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("settle_e1", valid0, 1'b0);
        @(posedge clk); #1;
        checkOutput("settle_e2", valid0, 1'b0);
        @(posedge clk); #1;
        checkOutput("settle_e3", valid0, 1'b1);
        checkOutput("settle_out", out0, 1'b0);

        applyStimulus(0, 4'd7, 4, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 4'(i), 4, tt0_ref[i]);

        // glitching input never settles
        prev_out = out0;
        for (int k = 0; k < 10; k++) begin
            in0 = (k % 2 == 1) ? 3'd2 : 3'd0;
            @(posedge clk); #1;
            checkOutput("glitch_valid", valid0, 1'b0);
            checkOutput("glitch_out", out0, prev_out);
        end
        q0.push_back(tt0_ref[2]);
        repeat (3) @(posedge clk);
        #1;

        applyStimulus(0, 4'd3, 4, tt0_ref[3]);

        // ld_en outside LOAD is ignored
        ld_en0 = 1'b1; ld_bit0 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("run_ld_en_busy", busy0, 1'b0);
            checkOutput("run_ld_en_done", done0, 1'b0);
        end
        ld_en0 = 1'b0;

        loadTable(8'h96, 1'b0);
        tt0_ref = 8'h96;
        applyStimulus(0, 4'd1, 4, tt0_ref[1]);

        // partial gapped load of ones, then restart with 8'h01
        ld_start0 = 1'b1;
        @(posedge clk); #1;
        ld_start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_en0 = (i != 2);
            ld_bit0 = 1'b1;
            @(posedge clk); #1;
            if (i == 2) begin
                ld_en0 = 1'b1;
                @(posedge clk); #1;
            end
        end
        ld_en0 = 1'b0;
        checkOutput("partial_busy", busy0, 1'b1);
        loadTable(8'h01, 1'b1);
        tt0_ref = 8'h01;
        applyStimulus(0, 4'd0, 4, 1'b1);
        applyStimulus(0, 4'd1, 4, 1'b0);

        // reset in the middle of a load on both instances
        ld_start0 = 1'b1; ld_start1 = 1'b1;
        @(posedge clk); #1;
        ld_start0 = 1'b0; ld_start1 = 1'b0;
        ld_en0 = 1'b1; ld_en1 = 1'b1; ld_bit0 = 1'b1; ld_bit1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ld_en0 = 1'b0; ld_en1 = 1'b0;
        checkOutput("preload_busy1", busy1, 1'b1);
        in0 = 3'd5;
        in1 = 4'hF;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy0", busy0, 1'b0);
        checkOutput("arst_busy1", busy1, 1'b0);
        checkOutput("arst_out0", out0, 1'b0);
        checkOutput("arst_valid0", valid0, 1'b0);
        checkOutput("arst_out1", out1, 1'b0);
        checkOutput("arst_valid1", valid1, 1'b0);
        checkOutput("arst_done0", done0, 1'b0);
        @(posedge clk); #1;
        tt0_ref = 8'hDF;
        q0.push_back(tt0_ref[5]);
        q1.push_back(tt1_ref[15]);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("arst_e1_valid0", valid0, 1'b0);
        checkOutput("arst_e1_valid1", valid1, 1'b0);
        @(posedge clk); #1;
        checkOutput("arst_e2_valid1", valid1, 1'b1);
        checkOutput("arst_e2_out1", out1, 1'b1);
        checkOutput("arst_e2_valid0", valid0, 1'b0);
        @(posedge clk); #1;
        checkOutput("arst_e3_valid0", valid0, 1'b1);
        checkOutput("arst_e3_out0", out0, 1'b0);

        for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 2, tt1_ref[i]);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb0_drain", q0.size(), 0);
        checkOutput("sb1_drain", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_settle_eval.md
# lut_settle_eval

Parametrised N-input truth-table evaluator with a runtime-reloadable table and an input-settling filter, the sequential successor to our fixed 3-input case-statement gates. It evaluates one Boolean function of N_IN inputs, publishing an output only once the input vector has been stable for SETTLE cycles, which models gate settling in the circuit benchmarks. The table can be replaced in-system through a serial load port without a reset. It sits between the stimulus/sequencer logic and the circuit-output monitor.

## Interface
- N_IN, 3: number of function inputs, 1..6.
- TT_RESET, 8'hDF (width 2**N_IN): truth table loaded at reset; bit i is the output for input index i.
- SETTLE, 2: consecutive stable cycles required before output update, 1..255.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in  in  N_IN  function inputs; index = in as unsigned, in[N_IN-1] is MSB.
- out  out  1  registered function value.
- out_valid  out  1  high while out reflects the current settled input under the current table.
- ld_start  in  1  begin or restart a table load.
- ld_en  in  1  ld_bit is valid this cycle (load in progress only).
- ld_bit  in  1  serial table bit, LSB (index 0) first.
- ld_busy  out  1  high in LOAD state.
- ld_done  out  1  one-cycle pulse on table commit.

## Operation
- Registers: tt (2**N_IN), shadow (2**N_IN), in_q (N_IN), cnt (8 b, saturating at SETTLE), bit counter (N_IN+1 b), state {RUN, LOAD}.
- Reset: tt=TT_RESET, in_q=0, cnt=0, out=0, out_valid=0, ld_busy=0, ld_done=0, state=RUN, shadow/bit counter=0.
- Settle filter (both states), every edge:
  - in != in_q: in_q<=in, cnt<=0, out_valid<=0, out holds.
  - else if cnt < SETTLE: cnt<=cnt+1; when cnt==SETTLE-1, out<=tt[in_q], out_valid<=1.
  - else: hold.
- RUN -> LOAD on ld_start: bit counter<=0; tt, out, out_valid unchanged.
- LOAD: each cycle with ld_en=1, shadow[count]<=ld_bit, count++. The cycle the 2**N_IN-th bit is accepted: tt<=shadow with that bit merged, ld_done=1 next cycle, state<=RUN, and the filter is forced to re-evaluate (cnt<=0, out_valid<=0).
- ld_start in LOAD: restart; bit counter<=0; partially shifted bits are discarded.
- ld_en in RUN: ignored. ld_en=0 in LOAD: stall, no timeout.
- Commit coinciding with an input change: input-change rule applies (in_q updated, cnt=0); there is no conflict.
- Async reset during LOAD: load abandoned, tt back to TT_RESET.

## Timing
- Input vector first present before edge t, then held: in_q captured at edge t; out/out_valid update at edge t+SETTLE.
- Any input change clears out_valid at the next edge.
- Load: ld_start at edge s, bits on edges s+1 .. s+2**N_IN (no stalls); tt commits at the last bit edge; ld_done is high for the following cycle; ld_busy falls with the commit edge.
- New table visible on out SETTLE edges after the commit edge with input held.
- ld_done is exactly one cycle; ld_busy and ld_done are never high together.

## Test plan
- Reset, defaults, in held at 3'b101 -> out_valid=0 until edge 2, then out=0, out_valid=1; in=3'b111 -> out_valid drops next edge, out=1 two edges later.
- Sweep all 8 inputs, each held 4 cycles -> out matches 8'hDF bit-by-bit (0 only at index 5).
- Glitch: in toggles 3'b000 <-> 3'b010 every cycle for 10 cycles -> out_valid stays 0 and out never changes.
- Load 8'h96 LSB-first with in held at 3'b011 -> ld_busy high 8 cycles, ld_done single pulse, out_valid drops, then out=0 after SETTLE edges; in=3'b001 -> out=1.
- Load with ld_en gaps plus ld_start after 5 bits, then a full 8'h01 load -> only 8'h01 is committed; in=0 -> out=1, in=1 -> out=0.
- Assert reset after 4 bits of a load -> ld_busy=0, all outputs 0, tt=8'hDF (in=5 -> out=0 after settle); repeat with N_IN=4, SETTLE=1, TT_RESET=16'h8000 -> out=1 only for in=4'hF, one edge after change.
